cpu_control_fsm: RTL and testbench

- Multi-cycle fetch/decode/sequencing unit for the 8-bit CPU.
- Sits directly upstream of the 8x8 register file and drives its INaddr, OUT1addr, OUT2addr and write-inhibit (busy_wait) inputs.
- Owns the PC, the instruction register, the ALU control lines and the data-memory handshake.
- Stalls on instruction-memory and data-memory busy_wait.

---
 rtl/cpu_defs.sv | 36 +++
 rtl/cpu_opcode_decoder.sv | 49 ++++
 rtl/cpu_control_fsm.sv | 139 +++++++++++++
 tb/tb_cpu_control_fsm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared encodings for the 8-bit CPU: opcodes, ALU operation codes, control
// FSM states and instruction field positions.
package cpu_defs;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_LWD   = 8'd8;
  localparam logic [7:0] OP_LWI   = 8'd9;
  localparam logic [7:0] OP_SWD   = 8'd10;
  localparam logic [7:0] OP_SWI   = 8'd11;

  localparam logic [2:0] ALU_FWD = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  localparam int FLD_OPC_LSB  = 24;
  localparam int FLD_DST_LSB  = 16;
  localparam int FLD_SRC1_LSB = 8;
  localparam int FLD_SRC2_LSB = 0;

endpackage

// File: rtl/cpu_opcode_decoder.sv
// Combinational opcode decode: ALU controls plus the instruction-class flags
// that steer the control FSM.
module cpu_opcode_decoder
  import cpu_defs::*;
#(
  parameter int OPC_WIDTH = 8
) (
  input  logic [OPC_WIDTH-1:0] opc_i,
  output logic [2:0]           aluop_o,
  output logic                 imm_sel_o,
  output logic                 neg_sel_o,
  output logic                 is_mem_o,
  output logic                 is_load_o,
  output logic                 is_branch_o,
  output logic                 is_jump_o,
  output logic                 writes_rf_o,
  output logic                 illegal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    aluop_o     = ALU_FWD;
    imm_sel_o   = 1'b0;
    neg_sel_o   = 1'b0;
    is_mem_o    = 1'b0;
    is_load_o   = 1'b0;
    is_branch_o = 1'b0;
    is_jump_o   = 1'b0;
    writes_rf_o = 1'b0;
    illegal_o   = 1'b0;
    case (opc_i)
      OP_LOADI: begin imm_sel_o = 1'b1; writes_rf_o = 1'b1; end
      OP_MOV:   writes_rf_o = 1'b1;
      OP_ADD:   begin aluop_o = ALU_ADD; writes_rf_o = 1'b1; end
      OP_SUB:   begin aluop_o = ALU_ADD; neg_sel_o = 1'b1; writes_rf_o = 1'b1; end
      OP_AND:   begin aluop_o = ALU_AND; writes_rf_o = 1'b1; end
      OP_OR:    begin aluop_o = ALU_OR;  writes_rf_o = 1'b1; end
      OP_J:     is_jump_o = 1'b1;
      OP_BEQ:   begin aluop_o = ALU_ADD; neg_sel_o = 1'b1; is_branch_o = 1'b1; end
      // Loads and stores compute their address by forwarding OUT2 or IMM.
      OP_LWD:   begin is_mem_o = 1'b1; is_load_o = 1'b1; writes_rf_o = 1'b1; end
      OP_LWI:   begin is_mem_o = 1'b1; is_load_o = 1'b1; writes_rf_o = 1'b1; imm_sel_o = 1'b1; end
      OP_SWD:   is_mem_o = 1'b1;
      OP_SWI:   begin is_mem_o = 1'b1; imm_sel_o = 1'b1; end
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute control for the 8-bit CPU: owns PC and IR,
// drives register-file addressing, ALU controls and the data-memory handshake.
module cpu_control_fsm
  import cpu_defs::*;
#(
  parameter int PC_WIDTH  = 8,
  parameter int OPC_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [31:0]         INSTRUCTION,
  input  logic                imem_busy_wait,
  input  logic                ZERO,
  input  logic                dmem_busy_wait,
  output logic [PC_WIDTH-1:0] PC,
  output logic                imem_read,
  output logic [2:0]          INaddr,
  output logic [2:0]          OUT1addr,
  output logic [2:0]          OUT2addr,
  output logic                rf_busy_wait,
  output logic [7:0]          IMM,
  output logic [2:0]          ALUOP,
  output logic                imm_sel,
  output logic                neg_sel,
  output logic                wb_sel,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic                illegal
);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;

  logic [2:0] dec_aluop;
  logic       dec_imm_sel, dec_neg_sel, dec_is_mem, dec_is_load;
  logic       dec_is_branch, dec_is_jump, dec_writes_rf, dec_illegal;

  cpu_opcode_decoder #(.OPC_WIDTH(OPC_WIDTH)) u_dec (
    .opc_i       (ir_q[FLD_OPC_LSB +: OPC_WIDTH]),
    .aluop_o     (dec_aluop),
    .imm_sel_o   (dec_imm_sel),
    .neg_sel_o   (dec_neg_sel),
    .is_mem_o    (dec_is_mem),
    .is_load_o   (dec_is_load),
    .is_branch_o (dec_is_branch),
    .is_jump_o   (dec_is_jump),
    .writes_rf_o (dec_writes_rf),
    .illegal_o   (dec_illegal)
  );

  // Branch offset is IR[23:16] sign-extended; sums wrap modulo 2^PC_WIDTH.
  logic [PC_WIDTH-1:0] pc_inc, pc_off, pc_tgt;
  assign pc_inc = pc_q + 1'b1;
  assign pc_off = PC_WIDTH'($signed(ir_q[FLD_DST_LSB +: 8]));
  assign pc_tgt = pc_inc + pc_off;

  assign PC       = pc_q;
  assign INaddr   = ir_q[FLD_DST_LSB  +: 3];
  assign OUT1addr = ir_q[FLD_SRC1_LSB +: 3];
  assign OUT2addr = ir_q[FLD_SRC2_LSB +: 3];
  assign IMM      = ir_q[FLD_SRC2_LSB +: 8];

  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[FLD_SRC1_LSB + 3 +: 5];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    imem_read    = 1'b0;
    rf_busy_wait = 1'b1;
    ALUOP        = ALU_FWD;
    imm_sel      = 1'b0;
    neg_sel      = 1'b0;
    wb_sel       = 1'b0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_read = 1'b1;
        if (!imem_busy_wait) begin
          ir_d    = INSTRUCTION;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        ALUOP   = dec_aluop;
        imm_sel = dec_imm_sel;
        neg_sel = dec_neg_sel;
        illegal = dec_illegal;
        if (dec_is_mem) begin
          state_d = S_MEM;
        end else begin
          rf_busy_wait = !dec_writes_rf;
          pc_d    = (dec_is_jump || (dec_is_branch && ZERO)) ? pc_tgt : pc_inc;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        ALUOP      = dec_aluop;
        imm_sel    = dec_imm_sel;
        dmem_read  = dec_is_load;
        dmem_write = !dec_is_load;
        if (!dmem_busy_wait) begin
          if (dec_is_load) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        wb_sel       = 1'b1;
        rf_busy_wait = 1'b0;
        pc_d         = pc_inc;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: walks a short program through every
// instruction class and checks outputs against hand-computed values.
module tb_cpu_control_fsm;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] INSTRUCTION;
  logic        imem_busy_wait, ZERO, dmem_busy_wait;
  logic [7:0]  PC;
  logic        imem_read, rf_busy_wait, imm_sel, neg_sel, wb_sel;
  logic        dmem_read, dmem_write, illegal;
  logic [2:0]  INaddr, OUT1addr, OUT2addr, ALUOP;
  logic [7:0]  IMM;

  int total = 0;
  int bad   = 0;

  // Per-instruction observations gathered by run_instr.
  int         cycles, writes, ill_cnt, rd_cnt, wr_cnt, imm_cnt, mem_cnt;
  logic [2:0] wr_addr, ex_aluop, ex_out1, ex_out2;
  logic       wr_wb, ex_neg, ex_imm, ex_ill;

  cpu_control_fsm dut (
    .CLK            (CLK),
    .reset          (reset),
    .INSTRUCTION    (INSTRUCTION),
    .imem_busy_wait (imem_busy_wait),
    .ZERO           (ZERO),
    .dmem_busy_wait (dmem_busy_wait),
    .PC             (PC),
    .imem_read      (imem_read),
    .INaddr         (INaddr),
    .OUT1addr       (OUT1addr),
    .OUT2addr       (OUT2addr),
    .rf_busy_wait   (rf_busy_wait),
    .IMM            (IMM),
    .ALUOP          (ALUOP),
    .imm_sel        (imm_sel),
    .neg_sel        (neg_sel),
    .wb_sel         (wb_sel),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .illegal        (illegal)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one instruction from FETCH back to FETCH, holding dmem_busy_wait high
  // for the first dbusy MEM cycles.
  task automatic run_instr(input logic [31:0] instr, input logic zero, input int dbusy);
    INSTRUCTION = instr;
    ZERO = zero;
    imem_busy_wait = 1'b0;
    dmem_busy_wait = 1'b0;
    cycles = 0; writes = 0; ill_cnt = 0; rd_cnt = 0; wr_cnt = 0; imm_cnt = 0; mem_cnt = 0;
    wr_addr = '0; wr_wb = 1'b0;
    do begin
      step();
      cycles++;
      if (!rf_busy_wait) begin writes++; wr_addr = INaddr; wr_wb = wb_sel; end
      if (illegal) ill_cnt++;
      if (dmem_read) rd_cnt++;
      if (dmem_write) wr_cnt++;
      if (imm_sel) imm_cnt++;
      if (dmem_read || dmem_write) begin
        mem_cnt++;
        dmem_busy_wait = (mem_cnt <= dbusy);
      end else begin
        dmem_busy_wait = 1'b0;
      end
      if (cycles == 2) begin
        ex_aluop = ALUOP; ex_neg = neg_sel; ex_imm = imm_sel;
        ex_out1 = OUT1addr; ex_out2 = OUT2addr; ex_ill = illegal;
      end
    end while (!imem_read && cycles < 40);
    if (!imem_read) check("timeout_back_to_fetch", 32'(cycles), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; INSTRUCTION = '0; imem_busy_wait = 1'b0; ZERO = 1'b0; dmem_busy_wait = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_imem_read", 32'(imem_read), 32'h1);
    check("rst_rf_busy", 32'(rf_busy_wait), 32'h1);
    check("rst_strobes", {28'h0, dmem_read, dmem_write, illegal, wb_sel}, 32'h0);
    check("rst_alu", {26'h0, ALUOP, imm_sel, neg_sel, 1'b0}, 32'h0);

    // loadi r2,200
    INSTRUCTION = 32'h000200C8;
    step();
    check("loadi_dec_rf_busy", 32'(rf_busy_wait), 32'h1);
    check("loadi_dec_imm_sel", 32'(imm_sel), 32'h0);
    step();
    check("loadi_ex_rf_busy", 32'(rf_busy_wait), 32'h0);
    check("loadi_ex_inaddr", 32'(INaddr), 32'd2);
    check("loadi_ex_imm", 32'(IMM), 32'd200);
    check("loadi_ex_imm_sel", 32'(imm_sel), 32'h1);
    check("loadi_ex_aluop", 32'(ALUOP), 32'd0);
    step();
    check("loadi_pc", 32'(PC), 32'h1);
    check("loadi_fetch_rf_busy", 32'(rf_busy_wait), 32'h1);
    check("loadi_fetch_imm_sel", 32'(imm_sel), 32'h0);

    // sub r4,r2,r1
    run_instr(32'h03040201, 1'b0, 0);
    check("sub_cycles", 32'(cycles), 32'd3);
    check("sub_out1", 32'(ex_out1), 32'd2);
    check("sub_out2", 32'(ex_out2), 32'd1);
    check("sub_aluop", 32'(ex_aluop), 32'd1);
    check("sub_neg", 32'(ex_neg), 32'h1);
    check("sub_writes", 32'(writes), 32'd1);
    check("sub_wr_addr", 32'(wr_addr), 32'd4);
    check("sub_pc", 32'(PC), 32'h2);

    // j +2 from PC=2 lands at 5
    run_instr(32'h06020000, 1'b0, 0);
    check("j_pc", 32'(PC), 32'h5);
    check("j_writes", 32'(writes), 32'd0);

    // beq -2 taken from PC=5 -> 4
    run_instr(32'h07FE0102, 1'b1, 0);
    check("beq_t_pc", 32'(PC), 32'h4);
    check("beq_t_writes", 32'(writes), 32'd0);
    check("beq_t_aluop", 32'(ex_aluop), 32'd1);
    check("beq_t_neg", 32'(ex_neg), 32'h1);
    check("beq_t_cycles", 32'(cycles), 32'd3);

    // mov r5,r1 brings PC back to 5; beq not taken -> 6
    run_instr(32'h01050100, 1'b0, 0);
    check("mov_pc", 32'(PC), 32'h5);
    check("mov_wr_addr", 32'(wr_addr), 32'd5);
    run_instr(32'h07FE0102, 1'b0, 0);
    check("beq_nt_pc", 32'(PC), 32'h6);
    check("beq_nt_writes", 32'(writes), 32'd0);

    // lwi r3,0x10 with 4 busy MEM cycles
    run_instr(32'h09030010, 1'b0, 4);
    check("lwi_cycles", 32'(cycles), 32'd9);
    check("lwi_dmem_read", 32'(rd_cnt), 32'd5);
    check("lwi_dmem_write", 32'(wr_cnt), 32'd0);
    check("lwi_writes", 32'(writes), 32'd1);
    check("lwi_wr_addr", 32'(wr_addr), 32'd3);
    check("lwi_wr_wb_sel", 32'(wr_wb), 32'h1);
    check("lwi_ex_imm_sel", 32'(ex_imm), 32'h1);
    check("lwi_pc", 32'(PC), 32'h7);

    // fetch stall for 3 cycles, then reset in MEM of swd
    INSTRUCTION = 32'h0A000102;
    imem_busy_wait = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("stall_imem_read", 32'(imem_read), 32'h1);
    check("stall_pc", 32'(PC), 32'h7);
    check("stall_ir_imm", 32'(IMM), 32'h10);
    check("stall_ir_inaddr", 32'(INaddr), 32'd3);
    imem_busy_wait = 1'b0;
    step();
    check("swd_dec_imm", 32'(IMM), 32'h02);
    step();
    step();
    dmem_busy_wait = 1'b1;
    check("swd_mem_write", 32'(dmem_write), 32'h1);
    step();
    check("swd_mem_hold", 32'(dmem_write), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    dmem_busy_wait = 1'b0;
    check("swd_rst_write", 32'(dmem_write), 32'h0);
    check("swd_rst_pc", 32'(PC), 32'h0);
    check("swd_rst_fetch", 32'(imem_read), 32'h1);
    check("swd_rst_ir", 32'(IMM), 32'h0);

    // j -2 from PC=0 wraps to 0xFF, then illegal opcode wraps PC to 0
    run_instr(32'h06FE0000, 1'b0, 0);
    check("jwrap_pc", 32'(PC), 32'hFF);
    run_instr(32'hFF000000, 1'b0, 0);
    check("ill_pulse", 32'(ill_cnt), 32'd1);
    check("ill_exec", 32'(ex_ill), 32'h1);
    check("ill_writes", 32'(writes), 32'd0);
    check("ill_cycles", 32'(cycles), 32'd3);
    check("ill_pc_wrap", 32'(PC), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
